// File: rtl/float_add_arbiter.sv
// Round-robin arbiter sharing one combinational half-precision adder between requesters A and B.
// Optional macro FLOAT_ARB_SUB_EN adds sub_a/sub_b ports for op1 - op2.
module float_adder (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] sum,
    output logic        overflow,
    output logic        zero,
    output logic        nan
);
    logic        a_nan, b_nan, a_inf, b_inf, swap;
    logic [15:0] x, y;
    logic [4:0]  ex, ey, d;
    logic [13:0] mx, my, norm;
    logic [14:0] s;
    logic [3:0]  lz;

    always_comb begin
        sum      = 16'h0000;
        overflow = 1'b0;
        zero     = 1'b0;
        nan      = 1'b0;
        norm     = 14'd0;
        a_nan = (&a[14:10]) && (|a[9:0]);
        b_nan = (&b[14:10]) && (|b[9:0]);
        a_inf = (&a[14:10]) && !(|a[9:0]);
        b_inf = (&b[14:10]) && !(|b[9:0]);
        // x always carries the larger magnitude, so the subtraction below never goes negative
        swap = b[14:0] > a[14:0];
        x    = swap ? b : a;
        y    = swap ? a : b;
        ex   = (x[14:10] == 5'd0) ? 5'd1 : x[14:10];
        ey   = (y[14:10] == 5'd0) ? 5'd1 : y[14:10];
        d    = ex - ey;
        mx   = {|x[14:10], x[9:0], 3'b000};
        my   = {|y[14:10], y[9:0], 3'b000} >> d;
        s    = (x[15] == y[15]) ? ({1'b0, mx} + {1'b0, my}) : ({1'b0, mx} - {1'b0, my});
        lz   = 4'd14;
        for (int i = 0; i < 14; i++) begin
            if (s[i]) lz = 4'(13 - i);
        end

        if (a_nan || b_nan || (a_inf && b_inf && (a[15] != b[15]))) begin
            sum = 16'h7E00;
            nan = 1'b1;
        end else if (a_inf || b_inf) begin
            sum = {x[15], 5'h1F, 10'd0};
        end else if (s == 15'd0) begin
            zero = 1'b1;
        end else if (s[14]) begin
            if (ex == 5'd30) begin
                overflow = 1'b1;
                sum      = {x[15], 5'h1F, 10'd0};
            end else begin
                sum = {x[15], ex + 5'd1, 10'(s >> 4)};
            end
        end else if ({1'b0, lz} < ex) begin
            norm = s[13:0] << lz;
            sum  = {x[15], ex - {1'b0, lz}, 10'(norm >> 3)};
        end else begin
            // result underflows into the subnormal range: shift only as far as exponent 1 allows
            norm = s[13:0] << (ex - 5'd1);
            sum  = {x[15], 5'd0, 10'(norm >> 3)};
        end
    end
endmodule

module float_add_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_a,
    input  logic        req_valid_b,
    output logic        req_ready_a,
    output logic        req_ready_b,
    input  logic [15:0] op1_a,
    input  logic [15:0] op2_a,
    input  logic [15:0] op1_b,
    input  logic [15:0] op2_b,
`ifdef FLOAT_ARB_SUB_EN
    input  logic        sub_a,
    input  logic        sub_b,
`endif
    output logic        res_valid_a,
    output logic        res_valid_b,
    input  logic        res_ready_a,
    input  logic        res_ready_b,
    output logic [15:0] result,
    output logic        overflow,
    output logic        zero,
    output logic        nan
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state, state_next;
    logic        last_b, owner_b, grant_a, grant_b;
    logic [15:0] op1_p0, op2_p0, op2_add, sum_c;
    logic        ovf_c, zero_c, nan_c;

    always_comb begin
        state_next = state;
        grant_a    = 1'b0;
        grant_b    = 1'b0;
        case (state)
            IDLE: begin
                grant_a = !rst && req_valid_a && (!req_valid_b || last_b);
                grant_b = !rst && req_valid_b && (!req_valid_a || !last_b);
                if (grant_a || grant_b) state_next = CALC;
            end
            CALC: state_next = DONE;
            DONE: if (owner_b ? res_ready_b : res_ready_a) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign req_ready_a = grant_a;
    assign req_ready_b = grant_b;
    assign res_valid_a = (state == DONE) && !owner_b;
    assign res_valid_b = (state == DONE) && owner_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            last_b  <= 1'b1;
            owner_b <= 1'b0;
        end else begin
            state <= state_next;
            if (grant_a || grant_b) begin
                last_b  <= grant_b;
                owner_b <= grant_b;
            end
        end
    end

    // Stage p0: operand capture at the request handshake
`ifdef FLOAT_ARB_SUB_EN
    logic sub_p0;
    always_ff @(posedge clk) begin
        if (grant_a || grant_b) sub_p0 <= grant_b ? sub_b : sub_a;
    end
    assign op2_add = sub_p0 ? {~op2_p0[15], op2_p0[14:0]} : op2_p0;
`else
    assign op2_add = op2_p0;
`endif

    always_ff @(posedge clk) begin
        if (grant_a || grant_b) begin
            op1_p0 <= grant_b ? op1_b : op1_a;
            op2_p0 <= grant_b ? op2_b : op2_a;
        end
    end

    float_adder u_adder (
        .a        (op1_p0),
        .b        (op2_add),
        .sum      (sum_c),
        .overflow (ovf_c),
        .zero     (zero_c),
        .nan      (nan_c)
    );

    // Stage p1: adder output registered in CALC, held through DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            result   <= 16'h0000;
            overflow <= 1'b0;
            zero     <= 1'b0;
            nan      <= 1'b0;
        end else if (state == CALC) begin
            result   <= sum_c;
            overflow <= ovf_c;
            zero     <= zero_c;
            nan      <= nan_c;
        end
    end
endmodule

// File: tb/tb_float_add_arbiter.sv
// Directed, table-driven bench for float_add_arbiter with hand-sequenced arbitration,
// back-pressure and reset corner cases. Sub vectors are included when FLOAT_ARB_SUB_EN is defined.
module tb_float_add_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_a, req_valid_b, req_ready_a, req_ready_b;
    logic [15:0] op1_a, op2_a, op1_b, op2_b;
    logic        res_valid_a, res_valid_b, res_ready_a, res_ready_b;
    logic [15:0] result;
    logic        overflow, zero, nan;
`ifdef FLOAT_ARB_SUB_EN
    logic        sub_a, sub_b;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        is_b;
        logic        sub;
        logic [15:0] op1;
        logic [15:0] op2;
        logic [15:0] res;
        logic [2:0]  flags;  // {overflow, zero, nan}
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    float_add_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid_a (req_valid_a),
        .req_valid_b (req_valid_b),
        .req_ready_a (req_ready_a),
        .req_ready_b (req_ready_b),
        .op1_a       (op1_a),
        .op2_a       (op2_a),
        .op1_b       (op1_b),
        .op2_b       (op2_b),
`ifdef FLOAT_ARB_SUB_EN
        .sub_a       (sub_a),
        .sub_b       (sub_b),
`endif
        .res_valid_a (res_valid_a),
        .res_valid_b (res_valid_b),
        .res_ready_a (res_ready_a),
        .res_ready_b (res_ready_b),
        .result      (result),
        .overflow    (overflow),
        .zero        (zero),
        .nan         (nan)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Starts and ends just after a falling edge with the block in IDLE.
    task automatic run_op(input vec_t v);
        if (v.is_b) begin
            req_valid_b = 1'b1; op1_b = v.op1; op2_b = v.op2;
`ifdef FLOAT_ARB_SUB_EN
            sub_b = v.sub;
`endif
        end else begin
            req_valid_a = 1'b1; op1_a = v.op1; op2_a = v.op2;
`ifdef FLOAT_ARB_SUB_EN
            sub_a = v.sub;
`endif
        end
        #1;
        chk("grant_winner", v.is_b ? req_ready_b : req_ready_a, 1);
        chk("grant_other",  v.is_b ? req_ready_a : req_ready_b, 0);
        @(posedge clk); @(negedge clk);
        req_valid_a = 1'b0; req_valid_b = 1'b0;
        chk("calc_no_res_valid", {res_valid_a, res_valid_b}, 0);
        @(posedge clk); @(negedge clk);
        chk("res_valid", {res_valid_a, res_valid_b}, v.is_b ? 2'b01 : 2'b10);
        chk("result", result, v.res);
        chk("flags", {overflow, zero, nan}, v.flags);
        if (v.is_b) res_ready_b = 1'b1; else res_ready_a = 1'b1;
        @(posedge clk); @(negedge clk);
        res_ready_a = 1'b0; res_ready_b = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        req_valid_a = 1'b1; req_valid_b = 1'b0;
        res_ready_a = 1'b0; res_ready_b = 1'b0;
        op1_a = 16'h3C00; op2_a = 16'h3C00; op1_b = 16'h0; op2_b = 16'h0;
`ifdef FLOAT_ARB_SUB_EN
        sub_a = 1'b0; sub_b = 1'b0;
`endif
        vecs.push_back('{1'b0, 1'b0, 16'h3C00, 16'h4000, 16'h4200, 3'b000});
        vecs.push_back('{1'b0, 1'b0, 16'h3C00, 16'hBC00, 16'h0000, 3'b010});
        vecs.push_back('{1'b1, 1'b0, 16'h7E00, 16'h3C00, 16'h7E00, 3'b001});
        vecs.push_back('{1'b0, 1'b0, 16'h7BFF, 16'h7BFF, 16'h7C00, 3'b100});
        vecs.push_back('{1'b1, 1'b0, 16'h4000, 16'h4000, 16'h4400, 3'b000});
        vecs.push_back('{1'b1, 1'b0, 16'h3C00, 16'h3C00, 16'h4000, 3'b000});
`ifdef FLOAT_ARB_SUB_EN
        vecs.push_back('{1'b0, 1'b1, 16'h4200, 16'h3C00, 16'h4000, 3'b000});
        vecs.push_back('{1'b1, 1'b1, 16'h3C00, 16'h3C00, 16'h0000, 3'b010});
`endif

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready_a", req_ready_a, 0);
        chk("rst_res_valid", {res_valid_a, res_valid_b}, 0);
        chk("rst_result", result, 16'h0000);
        chk("rst_flags", {overflow, zero, nan}, 3'b000);
        @(posedge clk); @(negedge clk);
        rst = 1'b0; req_valid_a = 1'b0;

        foreach (vecs[i]) run_op(vecs[i]);

        // Back-pressure: B owns the adder while A waits
        req_valid_b = 1'b1; op1_b = 16'h4000; op2_b = 16'h3C00;
        #1 chk("bp_grant_b", req_ready_b, 1);
        @(posedge clk); @(negedge clk);
        req_valid_a = 1'b1; op1_a = 16'h3C00; op2_a = 16'h3C00;
        #1 chk("bp_calc_ready_a", req_ready_a, 0);
        @(posedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_res_valid_b", {res_valid_a, res_valid_b}, 2'b01);
            chk("bp_result_stable", result, 16'h4200);
            chk("bp_req_ready", {req_ready_a, req_ready_b}, 2'b00);
        end
        res_ready_a = 1'b1;
        #1 chk("bp_ignore_other_ready", res_valid_b, 1);
        res_ready_a = 1'b0; res_ready_b = 1'b1;
        @(posedge clk); @(negedge clk);
        res_ready_b = 1'b0;
        #1 chk("bp_next_grant_a", {req_ready_a, req_ready_b}, 2'b10);
        req_valid_a = 1'b0; req_valid_b = 1'b0;
        #1 chk("bp_withdrawn", {req_ready_a, req_ready_b}, 2'b00);

        // Reset during CALC discards the operation
        @(negedge clk);
        req_valid_a = 1'b1; op1_a = 16'h3C00; op2_a = 16'h4000;
        #1 chk("rc_grant_a", req_ready_a, 1);
        @(posedge clk); @(negedge clk);
        req_valid_a = 1'b0; rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        chk("rc_no_res_valid", {res_valid_a, res_valid_b}, 0);
        chk("rc_result_cleared", result, 16'h0000);
        @(posedge clk); @(negedge clk);
        chk("rc_still_no_res_valid", {res_valid_a, res_valid_b}, 0);

        // Both requesting continuously, results always taken: A wins first, then alternation
        req_valid_a = 1'b1; op1_a = 16'h3C00; op2_a = 16'h3C00;
        req_valid_b = 1'b1; op1_b = 16'h4000; op2_b = 16'h4000;
        res_ready_a = 1'b1; res_ready_b = 1'b1;
        for (int k = 0; k < 6; k++) begin
            logic win_b;
            win_b = (k % 2) == 1;
            #1 chk("alt_grant", {req_ready_a, req_ready_b}, win_b ? 2'b01 : 2'b10);
            @(posedge clk); @(negedge clk);
            @(posedge clk); @(negedge clk);
            chk("alt_res_valid", {res_valid_a, res_valid_b}, win_b ? 2'b01 : 2'b10);
            chk("alt_result", result, win_b ? 16'h4400 : 16'h4000);
            @(posedge clk); @(negedge clk);
        end
        req_valid_a = 1'b0; req_valid_b = 1'b0;
        res_ready_a = 1'b0; res_ready_b = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("final_idle", {res_valid_a, res_valid_b, req_ready_a, req_ready_b}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
